regfile_mp: RTL

- Parametrised multi-port register file for the pipelined MIPS datapath.
- Replaces the single-write, 2-read monocycle register file.
- Adds:
  - a second write port for the long-latency/load writeback path,
  - optional write-to-read bypass, so the decode stage sees same-cycle writeback data,
  - a per-register pending scoreboard used by hazard detection.
- Sits between the decode stage (read ports, scoreboard set) and the writeback stages (write ports).

---
 rtl/regfile_mp.sv | 65 ++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: two-write, two-read register file with optional write bypass
// and a per-register pending scoreboard for hazard detection.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1,
    parameter bit BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_wa,
    output logic              pend_any
);
    localparam int NREGS = 2 ** ADDR_W;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_pend;
    logic              w_v0, w_v1, w_sb;
    logic [ADDR_W-1:0] w_ra   [2];
    logic [DATA_W-1:0] w_rd   [2];
    logic [1:0]        w_busy;
    // gating with reset also disables bypass while reset is asserted
    assign w_v0 = reset && we0 && !(ZERO_REG && wa0 == '0);
    assign w_v1 = reset && we1 && !(ZERO_REG && wa1 == '0);
    assign w_sb = reset && sb_set && !(ZERO_REG && sb_wa == '0);
    assign w_ra[0] = ra1;
    assign w_ra[1] = ra2;
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic w_h0, w_h1;
        assign w_h0      = BYPASS && w_v0 && wa0 == w_ra[p];
        assign w_h1      = BYPASS && w_v1 && wa1 == w_ra[p];
        assign w_rd[p]   = (ZERO_REG && w_ra[p] == '0) ? '0 : w_h1 ? wd1 : w_h0 ? wd0 : r_regs[w_ra[p]];
        assign w_busy[p] = r_pend[w_ra[p]] && !(w_h0 || w_h1);
    end
    assign rd1      = w_rd[0];
    assign rd2      = w_rd[1];
    assign busy1    = w_busy[0];
    assign busy2    = w_busy[1];
    assign pend_any = |r_pend;
    // port 1 assigned last so it wins a write conflict; scoreboard set last so it wins over clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_pend <= '0;
        end else begin
            if (w_v0) r_regs[wa0] <= wd0;
            if (w_v1) r_regs[wa1] <= wd1;
            if (w_v0) r_pend[wa0] <= 1'b0;
            if (w_v1) r_pend[wa1] <= 1'b0;
            if (w_sb) r_pend[sb_wa] <= 1'b1;
        end
    end
endmodule
